// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: CPU-side bus between the core and its run/step/breakpoint sequencer
interface cpu_run_ctrl_if #(parameter int CNT_W = 32);
  logic halt_req;
  logic [31:0] pc;
  logic [31:0] bp_addr;
  logic bp_valid;
  logic cpu_en;
  logic [1:0] state;
  logic [CNT_W-1:0] instr_cnt;
  logic timeout;
  modport master (
    output halt_req, pc, bp_addr, bp_valid,
    input cpu_en, state, instr_cnt, timeout
  );
  modport slave (
    input halt_req, pc, bp_addr, bp_valid,
    output cpu_en, state, instr_cnt, timeout
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: debounced run/step/halt sequencer driving cpu_en with PC breakpoint and retired count; CYCLE_LIMIT_EN adds the run-cycle limit and timeout
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W = 32
`ifdef CYCLE_LIMIT_EN
  ,
  parameter logic [31:0] MAX_RUN_CYCLES = 32'd10_000_000
`endif
) (
  input logic clk,
  input logic rst,
  input logic btn_run,
  input logic btn_step,
  input logic btn_halt,
  cpu_run_ctrl_if.slave io
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, STEP = 2'b10, BREAK = 2'b11} state_t;
  state_t state_q, state_d;
  logic [2:0] sync1_q, sync2_q, db_q, db_d, pulse_q, pulse_d;
  logic [2:0][DW-1:0] dcnt_q, dcnt_d;
  logic skip_q, skip_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic bp_hit, run_p, step_p, halt_p, limit;
  assign {halt_p, step_p, run_p} = pulse_q;
  assign bp_hit = io.bp_valid && io.pc == io.bp_addr && !skip_q;
  assign io.cpu_en = !io.halt_req && (state_q == STEP || (state_q == RUN && !bp_hit));
  assign io.state = state_q;
  assign io.instr_cnt = cnt_q;
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dcnt_d[i] = (sync2_q[i] == db_q[i] || dcnt_q[i] == DB_LAST) ? '0 : dcnt_q[i] + 1'b1;
      db_d[i] = (sync2_q[i] != db_q[i] && dcnt_q[i] == DB_LAST) ? sync2_q[i] : db_q[i];
    end
    pulse_d = db_d & ~db_q;
  end
  always_comb begin
    case (state_q)
      HALT: state_d = halt_p ? HALT : step_p ? STEP : run_p ? RUN : HALT;
      RUN: state_d = (halt_p || limit || io.halt_req) ? HALT : bp_hit ? BREAK : RUN;
      STEP: state_d = HALT;
      BREAK: state_d = halt_p ? HALT : step_p ? STEP : run_p ? RUN : BREAK;
      default: state_d = HALT;
    endcase
    skip_d = (state_q == BREAK && (state_d == RUN || state_d == STEP)) || (skip_q && !io.cpu_en);
    cnt_d = (io.cpu_en && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HALT;
      sync1_q <= '0;
      sync2_q <= '0;
      db_q <= '0;
      pulse_q <= '0;
      dcnt_q <= '0;
      skip_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= {btn_halt, btn_step, btn_run};
      sync2_q <= sync1_q;
      db_q <= db_d;
      pulse_q <= pulse_d;
      dcnt_q <= dcnt_d;
      skip_q <= skip_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef CYCLE_LIMIT_EN
  logic [31:0] run_cycles_q, run_cycles_d;
  logic timeout_q, timeout_d;
  assign io.timeout = timeout_q;
  always_comb begin
    limit = state_q == RUN && run_cycles_q == MAX_RUN_CYCLES - 32'd1;
    run_cycles_d = (state_q == RUN) ? run_cycles_q + 32'd1 : '0;
    timeout_d = limit || (timeout_q && !(state_q == HALT && state_d != HALT));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cycles_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      run_cycles_q <= run_cycles_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign limit = 1'b0;
  assign io.timeout = 1'b0;
`endif
endmodule
